heap_op_scheduler: RTL and testbench

Multi-requester front end for the custom heap instruction unit. It arbitrates push/pop/peek requests from `N_REQ` clients round-robin and issues one operation at a time into the heap stage. It waits for the stage's `out_v`, then routes the result back to the originating client. It tracks heap occupancy, so pops on an empty heap and pushes on a full heap are rejected locally and never reach the datapath.

---
 rtl/heap_op_scheduler_pkg.sv | 22 ++
 rtl/heap_op_scheduler_if.sv | 38 +++
 rtl/heap_op_scheduler_rr_arbiter.sv | 38 +++
 rtl/heap_op_scheduler.sv | 135 +++++++++++++
 tb/tb_heap_op_scheduler.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/heap_op_scheduler_pkg.sv
// heap_pkg: shared op codes, heap opcodes, response codes and scheduler states
package heap_pkg;
    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_PEEK = 2'b10;
    localparam logic [1:0] OP_ILL  = 2'b11;

    localparam logic [2:0] HP_PUSH = 3'b000;
    localparam logic [2:0] HP_POP  = 3'b001;
    localparam logic [2:0] HP_PEEK = 3'b010;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_REJ = 2'b01;
    localparam logic [1:0] ERR_TMO = 2'b10;
    localparam logic [1:0] ERR_ILL = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    function automatic logic [2:0] map_op(input logic [1:0] op);
        return op == OP_POP ? HP_POP : op == OP_PEEK ? HP_PEEK : HP_PUSH;
    endfunction
endpackage

// File: rtl/heap_op_scheduler_if.sv
// heap_op_scheduler_if: client request/response, config and heap-unit signals
interface heap_op_scheduler_if #(parameter int N_REQ = 4);
    logic [N_REQ-1:0]    req_v;
    logic [2*N_REQ-1:0]  req_op;
    logic [32*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    resp_v;
    logic [31:0]         resp_data;
    logic [1:0]          resp_err;
    logic [31:0]         cfg_heap_addr;
    logic                cfg_clear;
    logic                hp_in_v;
    logic [2:0]          hp_vrd1;
    logic [4:0]          hp_rd;
    logic [2:0]          hp_vrd2;
    logic [31:0]         hp_in_data;
    logic [31:0]         hp_in_heap_addr;
    logic [31:0]         hp_in_heap_size;
    logic                hp_out_v;
    logic [31:0]         hp_out_data;
    logic [31:0]         hp_out_heap_size;
    logic [31:0]         heap_size;
    logic                busy;

    modport slave (
        input  req_v, req_op, req_data, cfg_heap_addr, cfg_clear,
               hp_out_v, hp_out_data, hp_out_heap_size,
        output req_ready, resp_v, resp_data, resp_err, hp_in_v, hp_vrd1, hp_rd, hp_vrd2,
               hp_in_data, hp_in_heap_addr, hp_in_heap_size, heap_size, busy
    );

    modport master (
        output req_v, req_op, req_data, cfg_heap_addr, cfg_clear,
               hp_out_v, hp_out_data, hp_out_heap_size,
        input  req_ready, resp_v, resp_data, resp_err, hp_in_v, hp_vrd1, hp_rd, hp_vrd2,
               hp_in_data, hp_in_heap_addr, hp_in_heap_size, heap_size, busy
    );
endinterface

// File: rtl/heap_op_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin grant among N_REQ requesters; pointer moves past each winner
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_en,
    output logic [N_REQ-1:0] o_grant,
    output logic [IW-1:0]    o_idx
);
    logic [IW-1:0] r_ptr;
    logic          w_found;
    int            w_c;

    always_comb begin
        w_found = 1'b0;
        o_idx   = '0;
        w_c     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_c = (int'(r_ptr) + k) % N_REQ;
            if (!w_found && i_req[IW'(w_c)]) begin
                w_found = 1'b1;
                o_idx   = IW'(w_c);
            end
        end
    end

    assign o_grant = (w_found && i_en) ? N_REQ'(1) << o_idx : '0;

    always_ff @(posedge clk) begin
        if (!reset)
            r_ptr <= '0;
        else if (w_found && i_en)
            r_ptr <= (o_idx == IW'(N_REQ - 1)) ? '0 : o_idx + 1'b1;
    end
endmodule

// File: rtl/heap_op_scheduler.sv
// heap_op_scheduler: round-robin front end issuing one push/pop/peek at a time to the heap unit
module heap_op_scheduler
    import heap_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int CAPACITY = 64,
    parameter int TIMEOUT  = 32
) (
    input logic                 clk,
    input logic                 reset,
    heap_op_scheduler_if.slave  bus
);
    localparam int IW = $clog2(N_REQ);

    state_t          r_state;
    logic [IW-1:0]   r_client;
    logic [31:0]     r_data;
    logic [2:0]      r_vrd1;
    logic [5:0]      r_cnt;
    logic [31:0]     r_heap_size;
    logic [31:0]     r_addr;
    logic [31:0]     r_resp_data;
    logic [1:0]      r_resp_err;
    logic [N_REQ-1:0] r_resp_v;
    logic            r_hp_in_v;
    logic            r_busy;

    logic             w_en;
    logic [N_REQ-1:0] w_grant;
    logic [IW-1:0]    w_idx;
    logic [1:0]       w_op;
    logic [31:0]      w_data;
    logic [1:0]       w_err;

    // clear takes the IDLE cycle, so no grant may race it
    assign w_en = reset && !bus.cfg_clear && r_state == S_IDLE;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .i_req   (bus.req_v),
        .i_en    (w_en),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign w_op   = bus.req_op[2*w_idx +: 2];
    assign w_data = bus.req_data[32*w_idx +: 32];

    always_comb
        w_err = w_op == OP_ILL ? ERR_ILL :
                (w_op != OP_PUSH && r_heap_size == '0) ||
                (w_op == OP_PUSH && r_heap_size == 32'(CAPACITY)) ? ERR_REJ : ERR_OK;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_client    <= '0;
            r_data      <= '0;
            r_vrd1      <= '0;
            r_cnt       <= '0;
            r_heap_size <= '0;
            r_addr      <= '0;
            r_resp_data <= '0;
            r_resp_err  <= ERR_OK;
            r_resp_v    <= '0;
            r_hp_in_v   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_hp_in_v   <= 1'b0;
            r_resp_v    <= '0;
            r_resp_data <= '0;
            r_resp_err  <= ERR_OK;
            r_addr      <= bus.cfg_heap_addr;
            case (r_state)
                S_IDLE: begin
                    if (bus.cfg_clear) begin
                        r_heap_size <= '0;
                    end else if (|w_grant) begin
                        r_client <= w_idx;
                        r_data   <= w_data;
                        r_vrd1   <= map_op(w_op);
                        r_busy   <= 1'b1;
                        // rejected ops answer straight away without touching the heap
                        if (w_err != ERR_OK) begin
                            r_state    <= S_RESP;
                            r_resp_v   <= w_grant;
                            r_resp_err <= w_err;
                        end else begin
                            r_state   <= S_ISSUE;
                            r_hp_in_v <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                    r_cnt   <= '0;
                end
                S_WAIT: begin
                    if (bus.hp_out_v) begin
                        r_state     <= S_RESP;
                        r_heap_size <= bus.hp_out_heap_size;
                        r_resp_data <= bus.hp_out_data;
                        r_resp_v    <= N_REQ'(1) << r_client;
                    end else if (r_cnt == 6'(TIMEOUT - 1)) begin
                        r_state    <= S_RESP;
                        r_resp_err <= ERR_TMO;
                        r_resp_v   <= N_REQ'(1) << r_client;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready       = w_grant;
    assign bus.resp_v          = r_resp_v;
    assign bus.resp_data       = r_resp_data;
    assign bus.resp_err        = r_resp_err;
    assign bus.hp_in_v         = r_hp_in_v;
    assign bus.hp_vrd1         = r_vrd1;
    assign bus.hp_rd           = '0;
    assign bus.hp_vrd2         = '0;
    assign bus.hp_in_data      = r_data;
    assign bus.hp_in_heap_addr = r_addr;
    assign bus.hp_in_heap_size = r_heap_size;
    assign bus.heap_size       = r_heap_size;
    assign bus.busy            = r_busy;
endmodule

// File: tb/tb_heap_op_scheduler.sv
// tb_heap_op_scheduler: directed checks of arbitration, rejection, timeout, clear and reset
module tb_heap_op_scheduler;
    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    int          n_tests  = 0;
    int          n_fail   = 0;
    logic        m_answer = 1'b1;
    logic [31:0] m_ret    = '0;
    logic        m_v      = 1'b0;
    logic [31:0] m_data   = '0;
    logic [31:0] m_size   = '0;
    int          n_issue  = 0;

    heap_op_scheduler_if #(.N_REQ(4)) bus ();

    heap_op_scheduler #(.N_REQ(4), .CAPACITY(64), .TIMEOUT(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.hp_out_v         = m_v;
    assign bus.hp_out_data      = m_data;
    assign bus.hp_out_heap_size = m_size;

    always #5 clk = ~clk;

    // heap unit stand-in: answers one cycle after the issue strobe
    always @(posedge clk) begin
        m_v <= 1'b0;
        if (bus.hp_in_v) begin
            n_issue <= n_issue + 1;
            if (m_answer) begin
                m_v    <= 1'b1;
                m_data <= bus.hp_vrd1 == 3'b000 ? 32'd0 : m_ret;
                m_size <= bus.hp_vrd1 == 3'b000 ? bus.hp_in_heap_size + 1 :
                          bus.hp_vrd1 == 3'b001 ? bus.hp_in_heap_size - 1 : bus.hp_in_heap_size;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic legal_op(input int c, input logic [1:0] op, input logic [31:0] d,
                            input logic [31:0] exp_data, input logic [31:0] exp_size);
        bus.req_op[2*c +: 2]    = op;
        bus.req_data[32*c +: 32] = d;
        bus.req_v[c]            = 1'b1;
        #1 chk("ready", 32'(bus.req_ready), 32'(1) << c);
        @(negedge clk);
        bus.req_v[c] = 1'b0;
        chk("in_v", 32'(bus.hp_in_v), 1);
        chk("vrd1", 32'(bus.hp_vrd1), op == 2'b01 ? 1 : op == 2'b10 ? 2 : 0);
        chk("in_data", bus.hp_in_data, d);
        @(negedge clk);
        chk("early_resp", 32'(bus.resp_v), 0);
        @(negedge clk);
        chk("resp_v", 32'(bus.resp_v), 32'(1) << c);
        chk("resp_err", 32'(bus.resp_err), 0);
        chk("resp_data", bus.resp_data, exp_data);
        chk("heap_size", bus.heap_size, exp_size);
        @(negedge clk);
        chk("busy_off", 32'(bus.busy), 0);
    endtask

    task automatic rej_op(input int c, input logic [1:0] op, input logic [1:0] exp_err);
        bus.req_op[2*c +: 2] = op;
        bus.req_v[c]         = 1'b1;
        #1 chk("rej_ready", 32'(bus.req_ready), 32'(1) << c);
        @(negedge clk);
        bus.req_v[c] = 1'b0;
        chk("rej_resp_v", 32'(bus.resp_v), 32'(1) << c);
        chk("rej_err", 32'(bus.resp_err), 32'(exp_err));
        chk("rej_data", bus.resp_data, 0);
        chk("rej_in_v", 32'(bus.hp_in_v), 0);
        @(negedge clk);
        chk("rej_busy_off", 32'(bus.busy), 0);
    endtask

    initial begin
        int         k;
        int         n0;
        logic [3:0] acc;
        bus.req_v         = '0;
        bus.req_op        = '0;
        bus.req_data      = '0;
        bus.cfg_heap_addr = 32'h1000_0000;
        bus.cfg_clear     = 1'b0;
        bus.req_v[0]      = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_heap", bus.heap_size, 0);
        chk("rst_resp_v", 32'(bus.resp_v), 0);
        chk("rst_in_v", 32'(bus.hp_in_v), 0);
        bus.req_v = '0;
        reset     = 1'b1;
        @(negedge clk);
        chk("heap_addr", bus.hp_in_heap_addr, 32'h1000_0000);

        legal_op(0, 2'b00, 32'd10, 32'd0, 32'd1);

        do_reset;
        legal_op(1, 2'b00, 32'd20, 32'd0, 32'd1);
        legal_op(1, 2'b00, 32'd15, 32'd0, 32'd2);
        m_ret = 32'd15;
        legal_op(1, 2'b01, 32'd0, 32'd15, 32'd1);
        m_ret = 32'd20;
        legal_op(1, 2'b10, 32'd0, 32'd20, 32'd1);

        do_reset;
        n0 = n_issue;
        rej_op(2, 2'b01, 2'b01);
        chk("no_issue", 32'(n_issue), 32'(n0));
        rej_op(1, 2'b11, 2'b11);

        do_reset;
        for (int i = 0; i < 64; i++) legal_op(3, 2'b00, 32'(i), 32'd0, 32'(i + 1));
        rej_op(3, 2'b00, 2'b01);
        chk("full_size", bus.heap_size, 64);

        do_reset;
        bus.req_op = '0;
        bus.req_v  = 4'hF;
        #1;
        for (int g = 0; g < 5; g++) begin
            chk("rr_grant", 32'(bus.req_ready), 32'(1) << (g % 4));
            repeat (3) begin
                @(negedge clk);
                chk("rr_gap", 32'(bus.req_ready), 0);
            end
            if (g < 4) @(negedge clk);
        end
        bus.req_v = '0;
        @(negedge clk);
        chk("rr_size", bus.heap_size, 5);

        do_reset;
        m_answer = 1'b0;
        bus.req_op[7:6] = 2'b00;
        bus.req_v[3]    = 1'b1;
        #1 chk("tmo_ready", 32'(bus.req_ready), 32'h8);
        @(negedge clk);
        bus.req_v = '0;
        k = 1;
        while (k < 40 && bus.resp_v == '0) begin
            @(negedge clk);
            k++;
        end
        chk("tmo_cycle", 32'(k), 34);
        chk("tmo_resp_v", 32'(bus.resp_v), 32'h8);
        chk("tmo_err", 32'(bus.resp_err), 2);
        chk("tmo_data", bus.resp_data, 0);
        chk("tmo_heap", bus.heap_size, 0);
        @(negedge clk);
        chk("tmo_busy_off", 32'(bus.busy), 0);
        m_answer = 1'b1;

        do_reset;
        for (int i = 0; i < 3; i++) legal_op(0, 2'b00, 32'(i + 5), 32'd0, 32'(i + 1));
        bus.cfg_clear = 1'b1;
        bus.req_v[0]  = 1'b1;
        #1 chk("clr_ready", 32'(bus.req_ready), 0);
        @(negedge clk);
        chk("clr_heap", bus.heap_size, 0);
        chk("clr_busy", 32'(bus.busy), 0);
        bus.cfg_clear = 1'b0;
        bus.req_v     = '0;

        @(negedge clk);
        bus.req_op[1:0] = 2'b00;
        bus.req_v[0]    = 1'b1;
        #1 chk("mid_ready", 32'(bus.req_ready), 1);
        @(negedge clk);
        bus.req_v = '0;
        @(negedge clk);
        chk("mid_busy", 32'(bus.busy), 1);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        acc   = bus.resp_v;
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            acc = acc | bus.resp_v;
        end
        chk("mid_no_resp", 32'(acc), 0);
        chk("mid_heap", bus.heap_size, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
